// File: rtl/iter_mul_div_unit.sv
// iter_mul_div_unit
//   Iterative HI/LO multiply/divide unit for the E stage of the pipelined MIPS
//   core. The multiplier is a radix-2 shift-add engine and the divider is a
//   restoring divider. Both work on unsigned magnitudes and share one pair of
//   working registers. Sign correction, multiply-accumulate and the
//   architectural HI/LO write all happen in a single FIX cycle.
//
// Ports
//   clk      in   1      clock, all state changes on posedge
//   reset    in   1      synchronous, active-high; overrides start and cancel
//   start    in   1      op valid this cycle
//   op       in   4      0 NOP,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MADD,6 MADDU,
//                        7 MSUB,8 MSUBU,9 MTHI,10 MTLO, others NOP
//   src_a    in   WIDTH  rs: dividend / multiplicand / MTHI-MTLO data
//   src_b    in   WIDTH  rt: divisor / multiplier
//   cancel   in   1      flush: aborts an in-flight op, blocks start this cycle
//   rd_hi    in   1      read select, 1 = HI, 0 = LO
//   busy     out  1      iterative op in flight
//   rd_data  out  WIDTH  architectural HI or LO (combinational)
//
// Handshake: start is a valid and ~busy is the matching ready. An op transfers
//   on a posedge where start & ~busy & ~cancel. A start while busy is dropped,
//   not held; the hazard unit stalls the pipe on (start | busy), so the op is
//   re-presented until it is accepted.
//
// Timing: busy is high for exactly WIDTH+1 cycles after accept (WIDTH
//   iteration steps + one FIX cycle). HI/LO and busy change on the same edge.
module iter_mul_div_unit #(
    parameter int WIDTH  = 32,
    parameter bit EN_MAC = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             cancel,
    input  logic             rd_hi,
    output logic             busy,
    output logic [WIDTH-1:0] rd_data
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MADD  = 4'd5;
    localparam logic [3:0] OP_MADDU = 4'd6;
    localparam logic [3:0] OP_MSUB  = 4'd7;
    localparam logic [3:0] OP_MSUBU = 4'd8;
    localparam logic [3:0] OP_MTHI  = 4'd9;
    localparam logic [3:0] OP_MTLO  = 4'd10;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t state, state_next;

    // Architectural registers
    logic [WIDTH-1:0] hi, lo;

    // Working registers. For MUL: {w_hi,w_lo} is the shifting partial product
    // (w_lo starts as the multiplier) and opnd_b the multiplicand. For DIV:
    // w_hi is the partial remainder, w_lo the dividend shifting into the
    // quotient, opnd_b the divisor.
    logic [WIDTH-1:0] w_hi, w_lo, opnd_b;
    logic [CW-1:0]    cnt;
    logic             neg_q, neg_r, div_op, div_zero, mac_add, mac_sub;

    // Decode
    logic             op_mul, op_mac, op_div, op_sgn, accept;
    logic [WIDTH-1:0] mag_a, mag_b;

    // Iteration step
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_rem_next;

    // FIX-cycle results
    logic [2*WIDTH-1:0] prod, prod_s, mul_res;
    logic [WIDTH-1:0]   quo, rem;

    always_comb begin
        op_mul = (op == OP_MULT) || (op == OP_MULTU);
        op_mac = EN_MAC && ((op == OP_MADD) || (op == OP_MADDU) ||
                            (op == OP_MSUB) || (op == OP_MSUBU));
        op_div = (op == OP_DIV) || (op == OP_DIVU);
        op_sgn = (op == OP_MULT) || (op == OP_DIV) ||
                 (EN_MAC && ((op == OP_MADD) || (op == OP_MSUB)));
        accept = (state == S_IDLE) && start && !cancel;
        mag_a  = (op_sgn && src_a[WIDTH-1]) ? -src_a : src_a;
        mag_b  = (op_sgn && src_b[WIDTH-1]) ? -src_b : src_b;
    end

    always_comb begin
        mul_sum      = {1'b0, w_hi} + (w_lo[0] ? {1'b0, opnd_b} : '0);
        div_shift    = {w_hi, w_lo[WIDTH-1]};
        div_ge       = div_shift >= {1'b0, opnd_b};
        // The partial remainder stays below the divisor, so the difference
        // always fits in WIDTH bits.
        div_rem_next = div_ge ? WIDTH'(div_shift - {1'b0, opnd_b})
                              : div_shift[WIDTH-1:0];
    end

    // HI/LO cannot change while busy (nothing is accepted), so they serve
    // directly as the accumulate snapshot.
    always_comb begin
        prod    = {w_hi, w_lo};
        prod_s  = neg_q ? -prod : prod;
        mul_res = prod_s;
        if (mac_add) mul_res = {hi, lo} + prod_s;
        if (mac_sub) mul_res = {hi, lo} - prod_s;
        // Divide by zero: the restoring loop already leaves the dividend
        // magnitude as remainder, and its sign correction rebuilds src_a.
        // Only the quotient needs forcing to all ones.
        quo = div_zero ? '1 : (neg_q ? -w_lo : w_lo);
        rem = neg_r ? -w_hi : w_hi;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept && (op_mul || op_mac)) state_next = S_MUL;
                else if (accept && op_div)        state_next = S_DIV;
            end
            S_MUL, S_DIV: begin
                if (cancel)                  state_next = S_IDLE;
                else if (cnt == CW'(1))      state_next = S_FIX;
            end
            S_FIX:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi       <= '0;
            lo       <= '0;
            w_hi     <= '0;
            w_lo     <= '0;
            opnd_b   <= '0;
            cnt      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_op   <= 1'b0;
            div_zero <= 1'b0;
            mac_add  <= 1'b0;
            mac_sub  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (op == OP_MTHI) hi <= src_a;
                        if (op == OP_MTLO) lo <= src_a;
                        if (op_mul || op_mac || op_div) begin
                            cnt      <= CW'(WIDTH);
                            w_hi     <= '0;
                            w_lo     <= op_div ? mag_a : mag_b;
                            opnd_b   <= op_div ? mag_b : mag_a;
                            neg_q    <= op_sgn && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                            neg_r    <= op_sgn && src_a[WIDTH-1];
                            div_op   <= op_div;
                            div_zero <= op_div && (src_b == '0);
                            mac_add  <= op_mac && ((op == OP_MADD) || (op == OP_MADDU));
                            mac_sub  <= op_mac && ((op == OP_MSUB) || (op == OP_MSUBU));
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    if (cancel) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt - CW'(1);
                        if (state == S_MUL) begin
                            w_hi <= mul_sum[WIDTH:1];
                            w_lo <= {mul_sum[0], w_lo[WIDTH-1:1]};
                        end else begin
                            w_hi <= div_rem_next;
                            w_lo <= {w_lo[WIDTH-2:0], div_ge};
                        end
                    end
                end
                S_FIX: begin
                    if (!cancel) begin
                        if (div_op) begin
                            hi <= rem;
                            lo <= quo;
                        end else begin
                            hi <= mul_res[2*WIDTH-1:WIDTH];
                            lo <= mul_res[WIDTH-1:0];
                        end
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

    assign busy    = (state != S_IDLE);
    assign rd_data = rd_hi ? hi : lo;

endmodule
